sec09_queues_param_queue: RTL
=============================

Name: sec09_queues_param_queue

Overview:
Parametrised successor to the single-entry pipe queue: an N-entry, W-bit circular-buffer queue with a selectable flow-control mode (normal, pipe, bypass, pipe+bypass) and an occupancy count. It is dropped between latency-insensitive val/rdy stages in memory and network test harnesses. It replaces fixed-depth, fixed-mode queue instances.

Parameters:
p_type, QUEUE_NORMAL, flow-control mode: QUEUE_NORMAL, QUEUE_PIPE, QUEUE_BYPASS or QUEUE_PIPE_BYPASS (encodings 0-3).
p_msg_nbits, 32, message width in bits, >=1.
p_num_msgs, 2, queue depth, >=1, need not be a power of two.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; asserted (0) clears all control state immediately
istream_val  input  1  enqueue valid
istream_rdy  output  1  enqueue ready
istream_msg  input  p_msg_nbits  enqueue message
ostream_val  output  1  dequeue valid
ostream_rdy  input  1  dequeue ready
ostream_msg  output  p_msg_nbits  dequeue message
num_free_entries  output  $clog2(p_num_msgs+1)  free slots (p_num_msgs minus stored count)

Behaviour:
- Storage: p_num_msgs x p_msg_nbits array, plus enq_ptr and deq_ptr (width max(1,$clog2(p_num_msgs))) and count (width $clog2(p_num_msgs+1)).
- Reset (reset==0, async): enq_ptr=0, deq_ptr=0, count=0. Data array is not cleared. While reset is held: ostream_val=0, istream_rdy=1 (empty), num_free_entries=p_num_msgs.
- full = (count==p_num_msgs); empty = (count==0).
- Transfer rules: enq fires when istream_val&&istream_rdy. Deq fires when ostream_val&&ostream_rdy.
- QUEUE_NORMAL:
  - istream_rdy=!full; ostream_val=!empty; ostream_msg=array[deq_ptr].
  - Minimum latency 1 cycle. No combinational path between the two streams.
- QUEUE_PIPE:
  - istream_rdy=!full || ostream_rdy.
  - Combinational path ostream_rdy->istream_rdy. Full throughput when full.
- QUEUE_BYPASS:
  - When empty: ostream_val=istream_val and ostream_msg=istream_msg. Otherwise behaves as normal.
  - Combinational path istream_val/msg->ostream. Zero latency.
  - Bypass transfer (empty, both fire): no write, pointers and count unchanged.
- QUEUE_PIPE_BYPASS: both rules apply.
- State update per edge, for stored transfers (not bypass):
  - enq only: array[enq_ptr]<=msg, enq_ptr++, count++.
  - deq only: deq_ptr++, count--.
  - enq and deq together: write, both pointers advance, count unchanged.
- Pointer wrap: ptr==p_num_msgs-1 increments to 0. This includes non-power-of-two depths, e.g. depth 3: 0,1,2,0.
- p_num_msgs==1:
  - Pointers are constant 0.
  - In QUEUE_PIPE this is exactly the one-entry pipe queue behaviour.
- Overflow/underflow cannot occur by construction. Enq is ignored when rdy=0; deq is ignored when val=0.
- ostream_msg is don't-care when ostream_val=0.
- Outputs are stable and glitch-free only after combinational inputs settle. No registered outputs other than the state-derived signals.
- Illegal p_type or p_num_msgs<1: elaboration-time $error.
- Reset asserted mid-traffic: queued messages are discarded. The first post-reset enq lands in slot 0.

Decomposition:
- Shared package sec09_queues_pkg holds the QUEUE_NORMAL/PIPE/BYPASS/PIPE_BYPASS localparam encodings and a helper function for pointer width.
- One sub-module, sec09_queues_param_queue_ctrl, owns pointers, count, rdy/val and bypass-select generation.
- Top level holds the storage array and output mux.

Test Plan:
- Normal, depth 4, W=32: enq 0xA0..0xA3 with ostream_rdy=0 -> istream_rdy=0 after 4th enq, num_free_entries=0. Then drain -> 0xA0,0xA1,0xA2,0xA3 in order; num_free_entries returns to 4.
- Pipe, depth 2: fill with 0x11,0x22; hold istream_val with 0x33 and ostream_rdy=1 -> istream_rdy=1 same cycle; deq 0x11 and enq 0x33 on one edge; count stays 2.
- Bypass, depth 2, empty: istream_val=1 msg 0x55, ostream_rdy=1 -> ostream_val=1, ostream_msg=0x55 in the same cycle; count remains 0, num_free_entries=2.
- Depth 3 wrap: stream 10 messages 1..10 with ostream_rdy toggling 1,0,1,0... -> output order 1..10; no loss or duplication across the pointer wrap 2->0.
- Simultaneous enq/deq at count=1 in normal mode -> count stays 1; the next ostream_msg is the newly enqueued value.
- Async reset: assert reset=0 mid-cycle with 3 entries queued -> ostream_val=0 and num_free_entries=p_num_msgs before the next edge. After release, enq 0x77 then deq yields 0x77.

Source files
------------

// File: rtl/sec09_queues_pkg.sv
// Shared definitions for the parametrised val/rdy queue family.
//   QUEUE_* : flow-control mode encodings (0..3)
//   ptr_nbits()   : width of a slot pointer for a given depth (at least 1)
//   count_nbits() : width of an occupancy count 0..depth
package sec09_queues_pkg;

  localparam int QUEUE_NORMAL      = 0;
  localparam int QUEUE_PIPE        = 1;
  localparam int QUEUE_BYPASS      = 2;
  localparam int QUEUE_PIPE_BYPASS = 3;

  function automatic int ptr_nbits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_nbits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sec09_queues_param_queue_ctrl.sv
// Control half of the parametrised queue: enq/deq pointers, occupancy count,
// stream handshakes and the bypass select.
//   clk, reset        : clock, asynchronous active-low reset
//   istream_val/rdy   : enqueue handshake
//   ostream_val/rdy   : dequeue handshake
//   wen, waddr        : storage write strobe and slot
//   raddr             : storage read slot (head of queue)
//   bypass_sel        : output mux takes istream_msg instead of storage
//   num_free_entries  : depth minus stored count
//
// Handshake: a transfer happens on a rising edge where val and rdy are both
// high on that stream; val never waits on rdy in NORMAL mode, rdy depends on
// the other stream only in PIPE modes, and val/msg pass straight through only
// in BYPASS modes while the queue is empty.
module sec09_queues_param_queue_ctrl
  import sec09_queues_pkg::*;
#(
  parameter int p_type     = QUEUE_NORMAL,
  parameter int p_num_msgs = 2,
  localparam int PW        = ptr_nbits(p_num_msgs),
  localparam int CW        = count_nbits(p_num_msgs)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          istream_val,
  output logic          istream_rdy,
  output logic          ostream_val,
  input  logic          ostream_rdy,
  output logic          wen,
  output logic [PW-1:0] waddr,
  output logic [PW-1:0] raddr,
  output logic          bypass_sel,
  output logic [CW-1:0] num_free_entries
);

  localparam logic PIPE_MODE = (p_type == QUEUE_PIPE) || (p_type == QUEUE_PIPE_BYPASS);
  localparam logic BYP_MODE  = (p_type == QUEUE_BYPASS) || (p_type == QUEUE_PIPE_BYPASS);

  logic [PW-1:0] enq_ptr;
  logic [PW-1:0] deq_ptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic enq_fire;
  logic deq_fire;
  logic bypass_xfer;
  logic do_enq;
  logic do_deq;

  // Wraps at depth-1, so non-power-of-two depths cycle 0..depth-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_num_msgs - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full        = (count == CW'(p_num_msgs));
    empty       = (count == '0);
    istream_rdy = !full || (PIPE_MODE && ostream_rdy);
    ostream_val = !empty || (BYP_MODE && istream_val);
    bypass_sel  = BYP_MODE && empty;
    enq_fire    = istream_val && istream_rdy;
    deq_fire    = ostream_val && ostream_rdy;
    // A message passed straight through never touches storage.
    bypass_xfer = bypass_sel && enq_fire && deq_fire;
    do_enq      = enq_fire && !bypass_xfer;
    do_deq      = deq_fire && !bypass_xfer;
    wen         = do_enq;
    waddr       = enq_ptr;
    raddr       = deq_ptr;
    num_free_entries = CW'(p_num_msgs) - count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (do_enq) enq_ptr <= ptr_inc(enq_ptr);
      if (do_deq) deq_ptr <= ptr_inc(deq_ptr);
      if (do_enq && !do_deq)      count <= count + CW'(1);
      else if (do_deq && !do_enq) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/sec09_queues_param_queue.sv
// N-entry, W-bit circular-buffer val/rdy queue with selectable flow control
// (normal, pipe, bypass, pipe+bypass) and a free-slot count.
//   clk, reset        : clock, asynchronous active-low reset
//   istream_val/rdy/msg : enqueue stream
//   ostream_val/rdy/msg : dequeue stream
//   num_free_entries  : p_num_msgs minus stored count
// Storage is not reset; only the control state is.
module sec09_queues_param_queue
  import sec09_queues_pkg::*;
#(
  parameter int p_type      = QUEUE_NORMAL,
  parameter int p_msg_nbits = 32,
  parameter int p_num_msgs  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               istream_val,
  output logic                               istream_rdy,
  input  logic [p_msg_nbits-1:0]             istream_msg,
  output logic                               ostream_val,
  input  logic                               ostream_rdy,
  output logic [p_msg_nbits-1:0]             ostream_msg,
  output logic [$clog2(p_num_msgs+1)-1:0]    num_free_entries
);

  localparam int PW = ptr_nbits(p_num_msgs);

  if ((p_type < QUEUE_NORMAL) || (p_type > QUEUE_PIPE_BYPASS)) begin : g_bad_type
    $error("sec09_queues_param_queue: illegal p_type %0d", p_type);
  end
  if (p_num_msgs < 1) begin : g_bad_depth
    $error("sec09_queues_param_queue: p_num_msgs must be >= 1 (got %0d)", p_num_msgs);
  end

  logic                   wen;
  logic [PW-1:0]          waddr;
  logic [PW-1:0]          raddr;
  logic                   bypass_sel;
  logic [p_msg_nbits-1:0] mem [p_num_msgs];

  sec09_queues_param_queue_ctrl #(
    .p_type     (p_type),
    .p_num_msgs (p_num_msgs)
  ) u_ctrl (
    .clk              (clk),
    .reset            (reset),
    .istream_val      (istream_val),
    .istream_rdy      (istream_rdy),
    .ostream_val      (ostream_val),
    .ostream_rdy      (ostream_rdy),
    .wen              (wen),
    .waddr            (waddr),
    .raddr            (raddr),
    .bypass_sel       (bypass_sel),
    .num_free_entries (num_free_entries)
  );

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= istream_msg;
  end

  // Empty bypass queues present the incoming message directly.
  always_comb begin
    ostream_msg = bypass_sel ? istream_msg : mem[raddr];
  end

endmodule
